// File: rtl/regi_shift.sv
// regi_shift: WIDTH-bit universal shift register with parallel load,
// logical/arithmetic shifts with serial in/out, rotates and synchronous clear.
// A saturating counter tracks shift-class ops since the last load/clear and
// raises a one-cycle done pulse when it reaches WIDTH.
//
// Ports:
//   clk   - clock, rising edge active
//   rst   - asynchronous active-high reset
//   ena   - operation enable; all state holds when 0
//   mode  - operation select (see mode_e)
//   d     - parallel load data
//   sin   - serial input bit
//   q     - register contents (registered)
//   sout  - bit shifted/rotated out by the last shift-class op (registered)
//   cnt   - shift-class ops since last load/clear, saturating at WIDTH
//   done  - one-cycle pulse when cnt moves from WIDTH-1 to WIDTH
module regi_shift #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic [CW-1:0]    cnt,
  output logic             done
);

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_LOAD  = 3'b001,
    MODE_SHL   = 3'b010,
    MODE_SHR   = 3'b011,
    MODE_ROL   = 3'b100,
    MODE_ROR   = 3'b101,
    MODE_ASR   = 3'b110,
    MODE_CLEAR = 3'b111
  } mode_e;

  localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             shift_op;
  mode_e            mode_sel;

  assign mode_sel = mode_e'(mode);

  always_comb begin
    q_d      = q_q;
    sout_d   = sout_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    shift_op = 1'b0;

    if (ena) begin
      case (mode_sel)
        MODE_HOLD: ;
        MODE_LOAD: begin
          q_d   = d;
          cnt_d = '0;
        end
        MODE_SHL: begin
          q_d      = {q_q[WIDTH-2:0], sin};
          sout_d   = q_q[WIDTH-1];
          shift_op = 1'b1;
        end
        MODE_SHR: begin
          q_d      = {sin, q_q[WIDTH-1:1]};
          sout_d   = q_q[0];
          shift_op = 1'b1;
        end
        MODE_ROL: begin
          q_d      = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          sout_d   = q_q[WIDTH-1];
          shift_op = 1'b1;
        end
        MODE_ROR: begin
          q_d      = {q_q[0], q_q[WIDTH-1:1]};
          sout_d   = q_q[0];
          shift_op = 1'b1;
        end
        MODE_ASR: begin
          q_d      = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
          sout_d   = q_q[0];
          shift_op = 1'b1;
        end
        MODE_CLEAR: begin
          q_d    = '0;
          sout_d = 1'b0;
          cnt_d  = '0;
        end
        default: ;
      endcase

      // Counter saturates at WIDTH; done fires only on the WIDTH-1 -> WIDTH step.
      if (shift_op) begin
        if (cnt_q < CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
        done_d = (cnt_q == CNT_LAST);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q    <= '0;
      sout_q <= 1'b0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      sout_q <= sout_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign q    = q_q;
  assign sout = sout_q;
  assign cnt  = cnt_q;
  assign done = done_q;

endmodule

// File: tb/tb_regi_shift.sv
// Self-checking bench for regi_shift (WIDTH=8): directed vector table,
// hand-written async-reset sequence, and randomized ops against a model.
module tb_regi_shift;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ena = 1'b0;
  logic [2:0]    mode = 3'b000;
  logic [W-1:0]  d = '0;
  logic          sin = 1'b0;
  logic [W-1:0]  q;
  logic          sout;
  logic [CW-1:0] cnt;
  logic          done;

  int passed = 0;
  int total  = 0;

  regi_shift #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .ena  (ena),
    .mode (mode),
    .d    (d),
    .sin  (sin),
    .q    (q),
    .sout (sout),
    .cnt  (cnt),
    .done (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          ena;
    logic [2:0]    mode;
    logic [7:0]    d;
    logic          sin;
    logic [7:0]    eq;
    logic          esout;
    logic [3:0]    ecnt;
    logic          edone;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] eq, input logic es,
                         input logic [3:0] ec, input logic ed);
    chk({tag, ".q"},    64'(q),    64'(eq));
    chk({tag, ".sout"}, 64'(sout), 64'(es));
    chk({tag, ".cnt"},  64'(cnt),  64'(ec));
    chk({tag, ".done"}, 64'(done), 64'(ed));
  endtask

  // Drive at the falling edge, sample 1 ns after the next rising edge.
  task automatic op(input logic e, input logic [2:0] m, input logic [7:0] dd, input logic s);
    @(negedge clk);
    ena = e; mode = m; d = dd; sin = s;
    @(posedge clk);
    #1;
  endtask

  task automatic addv(input logic e, input logic [2:0] m, input logic [7:0] dd, input logic s,
                      input logic [7:0] eq, input logic es, input logic [3:0] ec, input logic ed);
    vec_t v;
    v.ena = e; v.mode = m; v.d = dd; v.sin = s;
    v.eq = eq; v.esout = es; v.ecnt = ec; v.edone = ed;
    vecs.push_back(v);
  endtask

  // Behavioural model kept as plain integers.
  int mq, msout, mcnt, mdone;

  task automatic model_step(input logic e, input logic [2:0] m, input int dd, input int s);
    int top, bot;
    mdone = 0;
    if (!e) return;
    top = mq / 128;
    bot = mq % 2;
    if (m >= 3'd2 && m <= 3'd6) begin
      if (mcnt == W - 1) mdone = 1;
      if (mcnt < W) mcnt = mcnt + 1;
    end
    case (m)
      3'd1: begin mq = dd; mcnt = 0; end
      3'd2: begin msout = top; mq = (mq * 2) % 256 + s; end
      3'd3: begin msout = bot; mq = mq / 2 + s * 128; end
      3'd4: begin msout = top; mq = (mq * 2) % 256 + top; end
      3'd5: begin msout = bot; mq = mq / 2 + bot * 128; end
      3'd6: begin msout = bot; mq = mq / 2 + top * 128; end
      3'd7: begin mq = 0; msout = 0; mcnt = 0; end
      default: ;
    endcase
  endtask

  initial begin
    // 1. reset and hold
    for (int i = 0; i < 3; i++) addv(0, 3'b001, 8'hFF, 0, 8'h00, 0, 0, 0);
    // 2. load and enable gating
    addv(1, 3'b001, 8'hA5, 0, 8'hA5, 0, 0, 0);
    addv(0, 3'b001, 8'hF0, 0, 8'hA5, 0, 0, 0);
    addv(0, 3'b001, 8'hF0, 0, 8'hA5, 0, 0, 0);
    // 3. serialize
    addv(1, 3'b001, 8'hA5, 0, 8'hA5, 0, 0, 0);
    addv(1, 3'b010, 8'h00, 0, 8'h4A, 1, 1, 0);
    addv(1, 3'b010, 8'h00, 0, 8'h94, 0, 2, 0);
    addv(1, 3'b010, 8'h00, 0, 8'h28, 1, 3, 0);
    addv(1, 3'b010, 8'h00, 0, 8'h50, 0, 4, 0);
    addv(1, 3'b010, 8'h00, 0, 8'hA0, 0, 5, 0);
    addv(1, 3'b010, 8'h00, 0, 8'h40, 1, 6, 0);
    addv(1, 3'b010, 8'h00, 0, 8'h80, 0, 7, 0);
    addv(1, 3'b010, 8'h00, 0, 8'h00, 1, 8, 1);
    addv(1, 3'b010, 8'h00, 0, 8'h00, 0, 8, 0);
    // 4. deserialize
    addv(1, 3'b111, 8'h00, 0, 8'h00, 0, 0, 0);
    addv(1, 3'b011, 8'h00, 1, 8'h80, 0, 1, 0);
    addv(1, 3'b011, 8'h00, 1, 8'hC0, 0, 2, 0);
    addv(1, 3'b011, 8'h00, 0, 8'h60, 0, 3, 0);
    addv(1, 3'b011, 8'h00, 0, 8'h30, 0, 4, 0);
    addv(1, 3'b011, 8'h00, 0, 8'h18, 0, 5, 0);
    addv(1, 3'b011, 8'h00, 0, 8'h0C, 0, 6, 0);
    addv(1, 3'b011, 8'h00, 1, 8'h86, 0, 7, 0);
    addv(1, 3'b011, 8'h00, 1, 8'hC3, 0, 8, 1);
    addv(1, 3'b000, 8'h00, 0, 8'hC3, 0, 8, 0);
    // 5. rotate and arithmetic shift
    addv(1, 3'b001, 8'h81, 0, 8'h81, 0, 0, 0);
    addv(1, 3'b100, 8'h00, 0, 8'h03, 1, 1, 0);
    addv(1, 3'b001, 8'h84, 0, 8'h84, 1, 0, 0);
    addv(1, 3'b110, 8'h00, 1, 8'hC2, 0, 1, 0);
    addv(1, 3'b110, 8'h00, 1, 8'hE1, 0, 2, 0);
    // load at cnt=WIDTH-1 clears cnt without a done pulse; mixed shift modes count together
    addv(1, 3'b001, 8'hFF, 0, 8'hFF, 0, 0, 0);
    for (int i = 1; i <= 7; i++)
      addv(1, (i % 2 == 0) ? 3'b101 : 3'b100, 8'h00, 0, 8'hFF, 1, 4'(i), 0);
    addv(1, 3'b001, 8'h00, 0, 8'h00, 1, 0, 0);
    addv(1, 3'b010, 8'h00, 1, 8'h01, 0, 1, 0);
    // ena=0 holds state while shift mode is presented
    addv(0, 3'b010, 8'h00, 1, 8'h01, 0, 1, 0);

    // reset state
    #12;
    chk_all("reset", 8'h00, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      op(vecs[i].ena, vecs[i].mode, vecs[i].d, vecs[i].sin);
      chk_all($sformatf("vec%0d", i), vecs[i].eq, vecs[i].esout, vecs[i].ecnt, vecs[i].edone);
    end

    // 6. async reset mid-serialize
    op(1, 3'b001, 8'hFF, 0);
    for (int i = 0; i < 5; i++) op(1, 3'b010, 8'h00, 0);
    chk_all("pre_rst", 8'hE0, 1, 5, 0);
    #2 rst = 1'b1;
    #1;
    chk_all("async_rst", 8'h00, 0, 0, 0);
    op(1, 3'b010, 8'h00, 1);
    chk_all("rst_held", 8'h00, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    op(1, 3'b001, 8'h3C, 0);
    chk_all("post_rst_load", 8'h3C, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      op(1, 3'b000, 8'h00, 0);
      chk("post_rst_nodone", 64'(done), 64'(0));
    end

    // randomized ops against the model
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mq = 0; msout = 0; mcnt = 0; mdone = 0;
    for (int i = 0; i < 400; i++) begin
      logic       e;
      logic [2:0] m;
      logic [7:0] dd;
      logic       s;
      e  = ($urandom_range(0, 9) != 0);
      // bias toward shift-class ops so the counter saturates often
      m  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(2, 6));
      if ($urandom_range(0, 29) == 0) m = 3'b001;
      dd = 8'($urandom);
      s  = 1'($urandom);
      op(e, m, dd, s);
      model_step(e, m, int'(dd), int'(s));
      chk_all($sformatf("rnd%0d", i), 8'(mq), 1'(msout), 4'(mcnt), 1'(mdone));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/regi_shift.md
# regi_shift

Parametrised successor to the 8-bit enabled register: a WIDTH-bit universal shift register with parallel load, left/right shift with serial in/out, rotate, arithmetic shift and synchronous clear. A saturating shift counter raises a one-cycle `done` pulse after WIDTH shifts since the last load. It serves as the serializer/deserializer stage between parallel datapaths and single-bit links.

## Interface

- `WIDTH`, default 8. Register width; legal range 2 to 64.
- `CW`, localparam = $clog2(WIDTH+1). Counter width.

- `clk`  input  1  Clock; all state changes on its rising edge.
- `rst`  input  1  Reset, asynchronous and active-high.
- `ena`  input  1  Operation enable. When 0, all state holds.
- `mode`  input  3  Operation select; sampled only when `ena`=1.
- `d`  input  WIDTH  Parallel load data.
- `sin`  input  1  Serial input bit.
- `q`  output  WIDTH  Register contents (registered).
- `sout`  output  1  Bit shifted or rotated out by the last shift-class op (registered).
- `cnt`  output  CW  Shift-class ops since the last load or clear; saturates at WIDTH.
- `done`  output  1  One-cycle pulse when `cnt` reaches WIDTH.

## Operation

- Reset (`rst`=1, asynchronous): `q`=0, `sout`=0, `cnt`=0, `done`=0. State holds these values while `rst` is high.
- `ena`=0: `q`, `sout` and `cnt` hold; `done` is 0 on the next edge.
- With `ena`=1, the `mode` encodings are:
  - 000 hold: no change; `done`=0.
  - 001 load: `q`←`d`, `cnt`←0, `sout` holds.
  - 010 shift left: `q`←{q[W-2:0], sin}, `sout`←q[W-1].
  - 011 shift right: `q`←{sin, q[W-1:1]}, `sout`←q[0].
  - 100 rotate left: `q`←{q[W-2:0], q[W-1]}, `sout`←q[W-1].
  - 101 rotate right: `q`←{q[0], q[W-1:1]}, `sout`←q[0].
  - 110 arithmetic shift right: `q`←{q[W-1], q[W-1:1]}, `sout`←q[0]; `sin` is ignored.
  - 111 clear: `q`←0, `sout`←0, `cnt`←0.
- Shift-class ops are modes 010 to 110.
  - Each shift-class op increments `cnt` when `cnt`<WIDTH.
  - At WIDTH, `cnt` holds; it does not wrap.
- `done` is registered.
  - It is 1 for exactly one cycle, on the edge where a shift-class op moves `cnt` from WIDTH-1 to WIDTH.
  - It is 0 on every other edge, including further shifts while `cnt`=WIDTH.
- Load or clear with `cnt`=WIDTH-1 resets `cnt` to 0 and does not pulse `done`.

## Timing

- Latency is one cycle for every op: results appear on `q`/`sout`/`cnt`/`done` after the rising edge that samples `ena`/`mode`.
- `ena`, `mode`, `d` and `sin` must be stable around the rising edge of `clk`.
- No combinational path from any input to any output.
- Back-to-back ops every cycle are supported with no bubbles.
- Reset asserted mid-sequence:
  - Outputs go to reset values immediately, without waiting for `clk`.
  - Any pending `done` is lost.
  - The first op after `rst` deasserts executes on the first rising edge with `rst`=0.
- `cnt`/`done` semantics are identical for all shift-class modes; mixing modes within one count is allowed.

## Test plan

All scenarios use WIDTH=8.

1. Reset and hold:
   - Stimulus: `rst`=1 for 20 ns, then 0; `ena`=0 with `d`=8'hFF for 3 cycles.
   - Required: `q`=8'h00, `sout`=0, `cnt`=0, `done`=0 throughout.
2. Load and enable gating:
   - Stimulus: `mode`=001, `d`=8'hA5, `ena`=1 for one cycle, then `ena`=0 with `d`=8'hF0.
   - Required: `q`=8'hA5 after the first edge and stays 8'hA5.
3. Serialize:
   - Stimulus: load 8'hA5, then 8 cycles of `mode`=010 with `sin`=0.
   - Required: `sout` sequence 1,0,1,0,0,1,0,1; final `q`=8'h00; `cnt` counts 1 to 8; `done`=1 only after the 8th shift.
   - A 9th shift keeps `cnt`=8 with `done`=0.
4. Deserialize:
   - Stimulus: clear (`mode`=111), then 8 cycles of `mode`=011 with `sin` = 1,1,0,0,0,0,1,1.
   - Required: `q`=8'hC3 and `done` pulses once.
5. Rotate and arithmetic shift:
   - Stimulus: load 8'h81; `mode`=100 gives `q`=8'h03 and `sout`=1.
   - Then load 8'h84; `mode`=110 twice gives 8'hC2 then 8'hE1, with `sout` = 0 then 0.
6. Asynchronous reset mid-serialize:
   - Stimulus: load 8'hFF, 5 shifts, then `rst`=1 between clock edges.
   - Required: `q`=8'h00 and `cnt`=0 before the next edge; no `done` pulse follows.
